// File: rtl/mlp_mac_pipe.sv
// Pipelined signed MAC for one MLP neuron lane: framed dot-product accumulation + round/saturate.
// Optional MLP_MAC_BIAS_EN adds a per-frame bias input that seeds the accumulator.
module mlp_mac_pipe #(
  parameter int A_W        = 16,
  parameter int B_W        = 27,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 16,
  parameter int FRAC_SH    = 11,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
`ifdef MLP_MAC_BIAS_EN
  input  logic signed [OUT_W-1:0] bias,
`endif
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int P_W = A_W + B_W;
  localparam int Q_W = ACC_W + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  // index 0 is the input register, 1..MUL_STAGES the product registers
  logic [MUL_STAGES:0]                vld_pipe_q;
  logic [MUL_STAGES:0]                first_pipe_q;
  logic [MUL_STAGES:0]                last_pipe_q;
  logic signed [A_W-1:0]              a_q;
  logic signed [B_W-1:0]              b_q;
  logic [MUL_STAGES-1:0][ACC_W-1:0]   prod_q;

  logic signed [P_W-1:0]   prod_full;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] prod_acc;
  logic signed [ACC_W-1:0] init_val;

  assign prod_full = a_q * b_q;
  assign prod_ext  = ACC_W'(prod_full);
  assign prod_acc  = prod_q[MUL_STAGES-1];

`ifdef MLP_MAC_BIAS_EN
  logic [MUL_STAGES:0][OUT_W-1:0] bias_pipe_q;
  logic signed [OUT_W-1:0]        bias_acc;

  assign bias_acc = bias_pipe_q[MUL_STAGES];
  assign init_val = ACC_W'(bias_acc) <<< FRAC_SH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  bias_pipe_q <= '0;
    else if (ce) bias_pipe_q <= {bias_pipe_q[MUL_STAGES-1:0], bias};
  end
`else
  assign init_val = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
    end else if (ce) begin
      vld_pipe_q   <= {vld_pipe_q[MUL_STAGES-1:0],   in_valid};
      first_pipe_q <= {first_pipe_q[MUL_STAGES-1:0], in_first};
      last_pipe_q  <= {last_pipe_q[MUL_STAGES-1:0],  in_last};
      a_q          <= a;
      b_q          <= b;
      prod_q[0]    <= prod_ext;
      for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  // Accumulate stage: a frame restarts in IDLE or on in_first; the final sum is registered into fin_q.
  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] fin_q;
  logic                    fin_vld_q;
  logic                    acc_vld, acc_first, acc_last, restart;
  logic signed [ACC_W-1:0] sum_d;

  assign acc_vld   = vld_pipe_q[MUL_STAGES];
  assign acc_first = first_pipe_q[MUL_STAGES];
  assign acc_last  = last_pipe_q[MUL_STAGES];
  assign restart   = (state_q == IDLE) || acc_first;
  assign sum_d     = (restart ? init_val : acc_q) + prod_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      fin_q     <= '0;
      fin_vld_q <= 1'b0;
    end else if (ce) begin
      fin_vld_q <= 1'b0;
      if (acc_vld) begin
        if (acc_last) begin
          fin_q     <= sum_d;
          fin_vld_q <= 1'b1;
          state_q   <= IDLE;
        end else begin
          acc_q   <= sum_d;
          state_q <= ACCUM;
        end
      end
    end
  end

  // One guard bit keeps the rounding add from overflowing before the shift.
  logic signed [Q_W-1:0] rnd;

  generate
    if (FRAC_SH > 0) begin : g_round
      localparam logic signed [Q_W-1:0] RND_ADD = Q_W'(1) <<< (FRAC_SH - 1);
      assign rnd = (Q_W'(fin_q) + RND_ADD) >>> FRAC_SH;
    end else begin : g_noround
      assign rnd = Q_W'(fin_q);
    end
  endgenerate

  localparam logic signed [Q_W-1:0] OMAX = (Q_W'(1) <<< (OUT_W - 1)) - Q_W'(1);
  localparam logic signed [Q_W-1:0] OMIN = -(Q_W'(1) <<< (OUT_W - 1));

  logic signed [OUT_W-1:0] out_data_d;
  logic                    out_sat_d;

  always_comb begin
    out_data_d = rnd[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (rnd > OMAX) begin
      out_data_d = OMAX[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end else if (rnd < OMIN) begin
      out_data_d = OMIN[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end
  end

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (ce) begin
      out_valid_q <= fin_vld_q;
      if (fin_vld_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/mlp_mac_pipe.md
Name: mlp_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate engine for the MLP datapath.
- Successor to the fixed 16x27 four-stage multiplier. Adds:
  - configurable operand, accumulator and output widths;
  - configurable multiplier depth;
  - framed dot-product accumulation (first/last flags) with a valid handshake;
  - round-and-saturate output quantisation.
- Sits between the weight/activation fetch logic and the activation-function stage; one instance per neuron lane.

Parameters:
- A_W, 16, signed activation operand width.
- B_W, 27, signed weight operand width.
- ACC_W, 48, accumulator width; must be >= A_W+B_W.
- OUT_W, 16, signed output width.
- FRAC_SH, 11, arithmetic right shift applied to the accumulator before saturation; 0 means no shift and no rounding.
- MUL_STAGES, 2, product pipeline registers after the input registers; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register, including valid bits.
- in_valid  in  1  a/b/in_first/in_last are valid this cycle.
- in_first  in  1  first term of a dot product.
- in_last  in  1  last term of a dot product.
- a  in  A_W  signed activation.
- b  in  B_W  signed weight.
- out_valid  out  1  one-cycle pulse; out_data/out_sat hold a new result.
- out_data  out  OUT_W  signed, rounded, saturated dot product.
- out_sat  out  1  out_data was clipped.

Behaviour:
- Reset (asynchronous, reset=0): all pipeline data and valid/flag registers go to 0; out_valid=0, out_data=0, out_sat=0; FSM enters IDLE. Release is synchronous to clk. Reset mid-frame discards the partial sum with no output.
- Pipeline, all stages advancing only when ce=1:
  - stage 0 registers a, b, valid and flags;
  - MUL_STAGES registers carry the full-precision signed product (A_W+B_W bits, sign-extended to ACC_W) with its valid and flags;
  - accumulate stage;
  - output stage.
- Latency: the in_last beat accepted at edge t gives out_valid=1 after edge t+MUL_STAGES+2. The count is in ce=1 cycles; each ce=0 cycle adds one.
- Throughput: one term per ce=1 cycle, no back-pressure. A new frame may start on the beat immediately after in_last.
- Accumulator FSM, acting on beats arriving at the accumulate stage with valid=1:
  - IDLE: on a valid beat, acc <= product. in_first is implied in IDLE. Go to ACCUM unless in_last is set.
  - ACCUM, in_first=1: acc <= product, discarding the unfinished frame without output; stay in ACCUM unless in_last is set.
  - ACCUM, in_first=0: acc <= acc + product.
  - in_last=1 in any state: the final sum (including this product) goes to the output stage; return to IDLE.
  - in_first=1 and in_last=1 together: a single-term result.
  - Beats with valid=0 never change acc or the FSM.
- Accumulator arithmetic wraps modulo 2^ACC_W; no internal saturation.
- Output quantisation:
  - if FRAC_SH>0, add 2^(FRAC_SH-1) (round half up), then arithmetic shift right by FRAC_SH;
  - clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - out_sat=1 iff the clamp was applied.
- out_data/out_sat hold their value until the next result. out_valid is high for exactly one ce=1 cycle per result and holds its level while ce=0.

Optional Feature:
- Macro MLP_MAC_BIAS_EN.
- When defined: adds input port bias (OUT_W, signed), sampled with the first beat of each frame and carried down the pipeline alongside it. The accumulator starts at sign-extended (bias << FRAC_SH) + product rather than product.
- When undefined: the port is absent and frames start from the product alone.

Test Plan:
- Defaults, frame a={2048,2048,-2048,1024}, b={100,200,50,400} with first/last on beats 0/3 -> a single out_valid exactly MUL_STAGES+2 cycles after the last beat, out_data=450, out_sat=0.
- Rounding: single-term frames a=1, b=1024 -> out_data=1; a=1, b=1023 -> 0; a=-1, b=1024 -> 0; a=-1, b=1025 -> -1.
- Saturation: single term a=32767, b=67108863 -> out_data=32767, out_sat=1; a=-32768, b=67108863 -> out_data=-32768, out_sat=1.
- Back-to-back frames: {a=2048,b=5} then {a=2048,b=7} on consecutive cycles -> out_valid on two consecutive cycles with 5 then 7. in_first mid-frame drops the old frame with no output.
- ce stall: ce=0 for 3 cycles in the middle of the first scenario's frame -> result still 450; out_valid delayed by 3 cycles; no duplicated or lost terms.
- Reset: drive reset=0 for one cycle after 2 beats of a frame -> out_valid/out_data/out_sat are 0 immediately; a following frame {2048,9} single-term -> out_data=9, unaffected by the discarded terms.
